fft_bitrev_reorder: RTL and testbench

Output-side reader for the radix-2 SDF FFT pipeline. It consumes the butterfly chain's valid-qualified complex sample stream, which arrives in bit-reversed frequency order, and re-emits each N_POINTS frame in natural order. It uses a ping-pong double buffer so one frame is written while the previous frame is read. The output is a valid/ready stream with a last-sample marker for downstream CNN/conv logic.

---
 rtl/fft_bitrev_reorder.sv | 143 ++++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural-order frame reorder for the SDF FFT output, using a ping-pong bank pair.
// Optional sticky drop flag: define FFT_REORDER_OVF_FLAG_EN to add the ovf output.
module fft_bitrev_reorder #(
    parameter int DATA_WIDTH = 16,
    parameter int N_POINTS   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_val,
    input  logic [DATA_WIDTH-1:0] in_re,
    input  logic [DATA_WIDTH-1:0] in_im,
    output logic                  in_ready,
    output logic                  out_val,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_re,
    output logic [DATA_WIDTH-1:0] out_im,
    output logic                  out_last
`ifdef FFT_REORDER_OVF_FLAG_EN
    ,
    output logic                  ovf
`endif
);

    localparam int AW = $clog2(N_POINTS);
    localparam logic [AW-1:0] LAST_IDX = AW'(N_POINTS - 1);

    function automatic logic [AW-1:0] bitRev(input logic [AW-1:0] v);
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < AW; i++) begin
            r[i] = v[AW-1-i];
        end
        return r;
    endfunction

    // Bank select is the address MSB: entries [0,N) are bank 0, [N,2N) are bank 1.
    logic [DATA_WIDTH-1:0] r_memRe [2*N_POINTS];
    logic [DATA_WIDTH-1:0] r_memIm [2*N_POINTS];

    logic [1:0]            r_full;
    logic                  r_wsel;
    logic                  r_rsel;
    logic [AW-1:0]         r_wcnt;
    logic [AW-1:0]         r_rcnt;
    logic                  r_outVal;
    logic [DATA_WIDTH-1:0] r_outRe;
    logic [DATA_WIDTH-1:0] r_outIm;
    logic                  r_outLast;

    logic                  w_wr;
    logic                  w_wrDone;
    logic                  w_load;
    logic                  w_rdDone;
    logic [AW:0]           w_wrAddr;
    logic [AW:0]           w_rdAddr;
    logic [1:0]            w_fullNext;

    assign in_ready = !r_full[r_wsel];
    assign w_wr     = in_val && in_ready;
    assign w_wrDone = w_wr && (r_wcnt == LAST_IDX);
    assign w_load   = r_full[r_rsel] && (!r_outVal || out_ready);
    assign w_rdDone = w_load && (r_rcnt == LAST_IDX);
    assign w_wrAddr = {r_wsel, bitRev(r_wcnt)};
    assign w_rdAddr = {r_rsel, r_rcnt};

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_memRe[w_wrAddr] <= in_re;
            r_memIm[w_wrAddr] <= in_im;
        end
    end

    // A completing write and a completing read always hit different banks,
    // since writes need the bank empty and reads need it full.
    always_comb begin
        w_fullNext = r_full;
        if (w_wrDone) begin
            w_fullNext[r_wsel] = 1'b1;
        end
        if (w_rdDone) begin
            w_fullNext[r_rsel] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full <= 2'b00;
            r_wsel <= 1'b0;
            r_wcnt <= '0;
        end else begin
            r_full <= w_fullNext;
            if (w_wr) begin
                r_wcnt <= (r_wcnt == LAST_IDX) ? '0 : r_wcnt + 1'b1;
                if (w_wrDone) begin
                    r_wsel <= ~r_wsel;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsel    <= 1'b0;
            r_rcnt    <= '0;
            r_outVal  <= 1'b0;
            r_outRe   <= '0;
            r_outIm   <= '0;
            r_outLast <= 1'b0;
        end else if (w_load) begin
            r_outRe   <= r_memRe[w_rdAddr];
            r_outIm   <= r_memIm[w_rdAddr];
            r_outLast <= (r_rcnt == LAST_IDX);
            r_outVal  <= 1'b1;
            r_rcnt    <= (r_rcnt == LAST_IDX) ? '0 : r_rcnt + 1'b1;
            if (w_rdDone) begin
                r_rsel <= ~r_rsel;
            end
        end else if (out_ready) begin
            r_outVal  <= 1'b0;
            r_outLast <= 1'b0;
        end
    end

    assign out_val  = r_outVal;
    assign out_re   = r_outRe;
    assign out_im   = r_outIm;
    assign out_last = r_outLast;

`ifdef FFT_REORDER_OVF_FLAG_EN
    logic r_ovf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (in_val && !in_ready) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed self-checking bench for fft_bitrev_reorder (N_POINTS=16, DATA_WIDTH=16).
// Inputs are driven and outputs observed on the falling clock edge.
module tb_fft_bitrev_reorder;

    localparam int DW = 16;
    localparam int NP = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_val = 1'b0;
    logic [DW-1:0] in_re = '0;
    logic [DW-1:0] in_im = '0;
    logic          in_ready;
    logic          out_val;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_re;
    logic [DW-1:0] out_im;
    logic          out_last;
`ifdef FFT_REORDER_OVF_FLAG_EN
    logic          ovf;
`endif

    int testsRun = 0;
    int testsFailed = 0;

    // Natural output index n carries input sample bitrev(n), hand-computed for N=16.
    int tab [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    fft_bitrev_reorder #(.DATA_WIDTH(DW), .N_POINTS(NP)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_val    (in_val),
        .in_re     (in_re),
        .in_im     (in_im),
        .in_ready  (in_ready),
        .out_val   (out_val),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_last  (out_last)
`ifdef FFT_REORDER_OVF_FLAG_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expected);
        testsRun++;
        assert (obs === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] base);
        logic [15:0] v;
        for (int k = 0; k < NP; k++) begin
            @(negedge clk);
            v      = base + 16'(k);
            in_val = 1'b1;
            in_re  = v;
            in_im  = -v;
        end
        @(negedge clk);
        in_val = 1'b0;
    endtask

    task automatic checkItem(input string tag, input logic [15:0] base, input int n);
        logic [15:0] er;
        logic [15:0] ei;
        er = base + 16'(tab[n]);
        ei = -er;
        checkOutput({tag, "_val"}, out_val, 1);
        checkOutput({tag, "_re"}, out_re, er);
        checkOutput({tag, "_im"}, out_im, ei);
        checkOutput({tag, "_last"}, out_last, (n == NP - 1));
    endtask

    task automatic checkFrame(input string tag, input logic [15:0] base);
        for (int n = 0; n < NP; n++) begin
            @(negedge clk);
            checkItem(tag, base, n);
        end
    endtask

    initial begin
        int sent;
        int recv;
        int rdy;
        logic [15:0] v;

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_val", out_val, 0);
        checkOutput("rst_re", out_re, 0);
        checkOutput("rst_im", out_im, 0);
        checkOutput("rst_last", out_last, 0);
        checkOutput("rst_inReady", in_ready, 1);
`ifdef FFT_REORDER_OVF_FLAG_EN
        checkOutput("rst_ovf", ovf, 0);
`endif
        @(negedge clk);
        rst = 1'b1;

        // Scenario 1: single frame, first output one cycle after the 16th input
        applyStimulus(16'd0);
        checkOutput("t1_latency", out_val, 0);
        checkFrame("t1", 16'd0);
        @(negedge clk);
        checkOutput("t1_idle", out_val, 0);

        // Scenario 2: three back-to-back frames, no input stall and no output gaps
        for (int c = 0; c <= 65; c++) begin
            @(negedge clk);
            if (c < 48) checkOutput("t2_inReady", in_ready, 1);
            if (c == 16 || c == 65) checkOutput("t2_gapEdge", out_val, 0);
            if (c >= 17 && c <= 64) checkItem("t2", 16'(16 * ((c - 17) / 16)), (c - 17) % 16);
            in_val = (c < 48);
            v      = 16'(c);
            in_re  = v;
            in_im  = -v;
        end
        in_val = 1'b0;

        // Scenario 3: output stalled, third frame dropped
        out_ready = 1'b0;
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            checkOutput("t3_inReady", in_ready, (c < 32));
            if (c == 16) checkOutput("t3_notYet", out_val, 0);
            if (c >= 17) begin
                checkOutput("t3_holdVal", out_val, 1);
                checkOutput("t3_holdRe", out_re, 0);
                checkOutput("t3_holdLast", out_last, 0);
            end
`ifdef FFT_REORDER_OVF_FLAG_EN
            if (c == 32) checkOutput("t3_ovfClear", ovf, 0);
`endif
            v      = 16'(c);
            in_val = 1'b1;
            in_re  = v;
            in_im  = -v;
        end
        @(negedge clk);
        in_val    = 1'b0;
        out_ready = 1'b1;
        checkOutput("t3_stillRe", out_re, 0);
`ifdef FFT_REORDER_OVF_FLAG_EN
        checkOutput("t3_ovfSet", ovf, 1);
`endif
        for (int d = 1; d < 32; d++) begin
            @(negedge clk);
            checkItem("t3_drain", (d < 16) ? 16'd0 : 16'd16, d % 16);
        end
        @(negedge clk);
        checkOutput("t3_frame3Dropped", out_val, 0);
        checkOutput("t3_inReadyBack", in_ready, 1);

        // Scenario 6: five-cycle stall at output index 6
        applyStimulus(16'd0);
        checkOutput("t6_latency", out_val, 0);
        for (int n = 0; n <= 6; n++) begin
            @(negedge clk);
            checkItem("t6_pre", 16'd0, n);
        end
        out_ready = 1'b0;
        for (int s = 1; s <= 5; s++) begin
            @(negedge clk);
            checkOutput("t6_stallVal", out_val, 1);
            checkOutput("t6_stallRe", out_re, 6);
        end
        out_ready = 1'b1;
        for (int n = 7; n < NP; n++) begin
            @(negedge clk);
            checkItem("t6_post", 16'd0, n);
        end
        @(negedge clk);
        checkOutput("t6_idle", out_val, 0);

        // Scenario 4: random backpressure over four frames
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 1000 && recv < 64; cyc++) begin
            @(negedge clk);
            rdy = $urandom_range(0, 1);
            out_ready = rdy[0];
            if (out_val && rdy[0]) begin
                checkItem("t4", 16'(16 * (recv / 16)), recv % 16);
                recv++;
            end
            if (sent < 64 && in_ready) begin
                v      = 16'(sent);
                in_val = 1'b1;
                in_re  = v;
                in_im  = -v;
                sent++;
            end else begin
                in_val = 1'b0;
            end
        end
        checkOutput("t4_count", recv, 64);
        @(negedge clk);
        in_val    = 1'b0;
        out_ready = 1'b1;
        checkOutput("t4_noExtra", out_val, 0);

        // Scenario 5: reset in the middle of an input frame
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            v      = 16'(200 + k);
            in_val = 1'b1;
            in_re  = v;
            in_im  = -v;
        end
        @(negedge clk);
        in_val = 1'b0;
        checkOutput("t5_noOut", out_val, 0);
`ifdef FFT_REORDER_OVF_FLAG_EN
        checkOutput("t5_ovfSticky", ovf, 1);
`endif
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t5_rstVal", out_val, 0);
        checkOutput("t5_rstRe", out_re, 0);
        checkOutput("t5_rstIm", out_im, 0);
        checkOutput("t5_rstLast", out_last, 0);
        checkOutput("t5_rstInReady", in_ready, 1);
`ifdef FFT_REORDER_OVF_FLAG_EN
        checkOutput("t5_rstOvf", ovf, 0);
`endif
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t5_abortedSilent", out_val, 0);
        applyStimulus(16'd100);
        checkOutput("t5_latency", out_val, 0);
        checkFrame("t5", 16'd100);
        @(negedge clk);
        checkOutput("t5_idle", out_val, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
